// File: rtl/liteic_pkg.sv
// liteic shared definitions: address/data widths, slave address map,
// read connectivity matrix, response codes and the master read node FSM states.
package liteic_pkg;

    localparam int IC_ARADDR_WIDTH     = 32;
    localparam int IC_DATA_WIDTH       = 32;
    localparam int IC_RDATA_WIDTH      = IC_DATA_WIDTH + 2;
    localparam int IC_OFFS_WIDTH       = IC_ARADDR_WIDTH - 12;
    localparam int IC_NUM_MASTER_SLOTS = 2;
    localparam int IC_NUM_SLAVE_SLOTS  = 4;
    localparam int IC_SLV_IDX_WIDTH    =
        (IC_NUM_SLAVE_SLOTS > 1) ? $clog2(IC_NUM_SLAVE_SLOTS) : 1;

    // Upper 12 address bits that select each slave node.
    localparam logic [11:0] IC_SLV_BASE [IC_NUM_SLAVE_SLOTS] =
        '{12'h000, 12'h100, 12'h200, 12'h300};

    // Bit m of entry s set: master m may read slave s.
    localparam logic [IC_NUM_MASTER_SLOTS-1:0]
        IC_RD_CONN_MATRIX [IC_NUM_SLAVE_SLOTS] =
        '{2'b11, 2'b11, 2'b11, 2'b10};

    localparam logic [1:0] IC_RESP_OKAY   = 2'b00;
    localparam logic [1:0] IC_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_REQ,
        RD_RESP,
        RD_ERR
    } ic_mst_rd_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite read channels (AR and R).
// slv: node side (accepts AR, returns R); mst: initiator side.
interface axi_lite_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          ar_valid;
    logic          ar_ready;
    logic [AW-1:0] ar_addr;
    logic          r_valid;
    logic          r_ready;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;

    modport slv (
        input  ar_valid, ar_addr, r_ready,
        output ar_ready, r_valid, r_data, r_resp
    );

    modport mst (
        output ar_valid, ar_addr, r_ready,
        input  ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/liteic_priority_cd_s.sv
// Priority encoder: lowest set bit of in_vec wins.
// Ports: in_vec (raw requests), onehot (winner), idx (winner index), hit (any set).
module liteic_priority_cd_s #(
    parameter int IN_WIDTH  = 4,
    parameter int IDX_WIDTH = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1
) (
    input  logic [IN_WIDTH-1:0]  in_vec,
    output logic [IN_WIDTH-1:0]  onehot,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 hit
);
    // Scan from the top so the lowest set bit is written last.
    always_comb begin
        onehot = '0;
        idx    = '0;
        hit    = 1'b0;
        for (int i = IN_WIDTH - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_WIDTH'(i);
                hit       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/liteic_master_node_read.sv
// Per-master read node: decodes one AXI-Lite read, requests the slave column,
// returns its response, or answers DECERR locally for unmapped/unconnected reads.
// Ports: clk_i, rst_i (async, active-high), mst_axil (AR/R, node side),
// cbar_reqst_* (request column), cbar_resp_* (response column, {data,resp}).
module liteic_master_node_read
    import liteic_pkg::*;
#(
    parameter int MST_IDX = 0
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    axi_lite_if.slv                                      mst_axil,
    output logic [IC_OFFS_WIDTH-1:0]                     cbar_reqst_data_o,
    output logic [IC_NUM_SLAVE_SLOTS-1:0]                cbar_reqst_val_o,
    input  logic [IC_NUM_SLAVE_SLOTS-1:0]                cbar_reqst_rdy_i,
    input  logic [IC_NUM_SLAVE_SLOTS-1:0]                cbar_resp_val_i,
    output logic [IC_NUM_SLAVE_SLOTS-1:0]                cbar_resp_rdy_o,
    input  logic [IC_NUM_SLAVE_SLOTS-1:0][IC_RDATA_WIDTH-1:0] cbar_resp_data_i
);
    ic_mst_rd_state_t              state;
    logic [IC_OFFS_WIDTH-1:0]      addr_r;
    logic [IC_NUM_SLAVE_SLOTS-1:0] sel_r;
    logic [IC_SLV_IDX_WIDTH-1:0]   sel_idx_r;

    logic [IC_NUM_SLAVE_SLOTS-1:0] hit_vec;
    logic [IC_NUM_SLAVE_SLOTS-1:0] dec_onehot;
    logic [IC_SLV_IDX_WIDTH-1:0]   dec_idx;
    logic                          dec_hit;

    logic                          sel_resp_val;
    logic [IC_RDATA_WIDTH-1:0]     sel_resp_data;

    always_comb begin
        hit_vec = '0;
        for (int s = 0; s < IC_NUM_SLAVE_SLOTS; s++) begin
            hit_vec[s] =
                (mst_axil.ar_addr[IC_ARADDR_WIDTH-1 -: 12] == IC_SLV_BASE[s])
                && IC_RD_CONN_MATRIX[s][MST_IDX];
        end
    end

    liteic_priority_cd_s #(
        .IN_WIDTH  (IC_NUM_SLAVE_SLOTS),
        .IDX_WIDTH (IC_SLV_IDX_WIDTH)
    ) u_dec (
        .in_vec (hit_vec),
        .onehot (dec_onehot),
        .idx    (dec_idx),
        .hit    (dec_hit)
    );

    // Only the selected column is ever looked at.
    assign sel_resp_val  = cbar_resp_val_i[sel_idx_r];
    assign sel_resp_data = cbar_resp_data_i[sel_idx_r];

    assign cbar_reqst_data_o = addr_r;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= RD_IDLE;
            addr_r    <= '0;
            sel_r     <= '0;
            sel_idx_r <= '0;
        end else begin
            unique case (state)
                RD_IDLE: begin
                    if (mst_axil.ar_valid) begin
                        addr_r    <= mst_axil.ar_addr[IC_OFFS_WIDTH-1:0];
                        sel_r     <= dec_onehot;
                        sel_idx_r <= dec_idx;
                        state     <= dec_hit ? RD_REQ : RD_ERR;
                    end
                end
                RD_REQ: begin
                    if (cbar_reqst_rdy_i[sel_idx_r]) state <= RD_RESP;
                end
                RD_RESP: begin
                    if (sel_resp_val && mst_axil.r_ready) state <= RD_IDLE;
                end
                RD_ERR: begin
                    if (mst_axil.r_ready) state <= RD_IDLE;
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    // Outputs decode the registered state; RESP passes R through same-cycle.
    always_comb begin
        mst_axil.ar_ready = 1'b0;
        mst_axil.r_valid  = 1'b0;
        mst_axil.r_data   = '0;
        mst_axil.r_resp   = '0;
        cbar_reqst_val_o  = '0;
        cbar_resp_rdy_o   = '0;
        unique case (state)
            RD_IDLE: mst_axil.ar_ready = 1'b1;
            RD_REQ:  cbar_reqst_val_o = sel_r;
            RD_RESP: begin
                mst_axil.r_valid = sel_resp_val;
                {mst_axil.r_data, mst_axil.r_resp} = sel_resp_data;
                cbar_resp_rdy_o = mst_axil.r_ready ? sel_r : '0;
            end
            RD_ERR: begin
                mst_axil.r_valid = 1'b1;
                mst_axil.r_resp  = IC_RESP_DECERR;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_liteic_master_node_read.sv
// Testbench for liteic_master_node_read: randomized reads against slave-node
// models, with a scoreboard monitor checking every cycle and every R beat.
module tb_liteic_master_node_read;
    import liteic_pkg::*;

    localparam int NS  = IC_NUM_SLAVE_SLOTS;
    localparam int AW  = IC_ARADDR_WIDTH;
    localparam int OW  = IC_OFFS_WIDTH;
    localparam int RW  = IC_RDATA_WIDTH;
    localparam int MST = 0;

    typedef struct {
        bit             hit;
        int             slv;
        logic [OW-1:0]  off;
        logic [RW-1:0]  word;
        int             acc;
        bit             req_done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    axi_lite_if #(.AW(AW), .DW(IC_DATA_WIDTH)) bus ();

    logic [OW-1:0]          reqst_data;
    logic [NS-1:0]          reqst_val;
    logic [NS-1:0]          reqst_rdy;
    logic [NS-1:0]          resp_val;
    logic [NS-1:0]          resp_rdy;
    logic [NS-1:0][RW-1:0]  resp_data;

    liteic_master_node_read #(.MST_IDX(MST)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .mst_axil          (bus),
        .cbar_reqst_data_o (reqst_data),
        .cbar_reqst_val_o  (reqst_val),
        .cbar_reqst_rdy_i  (reqst_rdy),
        .cbar_resp_val_i   (resp_val),
        .cbar_resp_rdy_o   (resp_rdy),
        .cbar_resp_data_i  (resp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int ntests = 0;
    int nfail  = 0;
    int n_acc  = 0;
    int n_done = 0;

    exp_t             sb[$];
    logic [AW-1:0]    ar_q[$];

    int rdy_pct = 100, req_stall = 0, resp_dly_max = 0;
    int rr_pct = 100, rr_stall = 0, rand_left = 0;
    bit noise = 1'b0;

    task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference: lowest slave whose base matches and is connected, else -1.
    function automatic int model_decode(logic [AW-1:0] a);
        for (int s = 0; s < NS; s++)
            if (a[AW-1 -: 12] == IC_SLV_BASE[s] && IC_RD_CONN_MATRIX[s][MST])
                return s;
        return -1;
    endfunction

    // What slave node s returns for a given offset: {data, resp}.
    function automatic logic [RW-1:0] slave_word(int s, logic [OW-1:0] off);
        logic [7:0] tag;
        tag = 8'hA0 + 8'(s);
        return {tag, 4'h5, off[19:0], off[3:2]};
    endfunction

    function automatic logic [NS-1:0] oh(int s);
        logic [NS-1:0] v;
        v = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [11:0] b;
        int k;
        k = $urandom_range(0, 5);
        if (k < NS) b = IC_SLV_BASE[k];
        else b = 12'($urandom_range(0, 4095));
        return {b, 20'($urandom)};
    endfunction

    task automatic check_reset_vals(string nm);
        check(nm, {bus.ar_ready, bus.r_valid, bus.r_data, bus.r_resp,
                   reqst_val, resp_rdy, reqst_data}, {1'b1, 63'd0});
    endtask

    task automatic wait_drain(string nm, int budget);
        int n;
        n = 0;
        while ((ar_q.size() > 0 || bus.ar_valid || sb.size() > 0
                || rand_left > 0) && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        check({nm, "_drain"}, 128'(n < budget), 128'(1));
    endtask

    // AR driver: pushes the model's expectation at each AR handshake.
    initial begin : ar_driver
        exp_t e;
        int   m;
        bit   acc_last;
        acc_last = 1'b0;
        bus.ar_valid = 1'b0;
        bus.ar_addr  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.ar_valid = 1'b0;
                acc_last = 1'b0;
                continue;
            end
            if (acc_last) bus.ar_valid = 1'b0;
            acc_last = 1'b0;
            if (!bus.ar_valid) begin
                if (ar_q.size() > 0) begin
                    bus.ar_addr  = ar_q.pop_front();
                    bus.ar_valid = 1'b1;
                end else if (rand_left > 0 && $urandom_range(0, 2) != 0) begin
                    bus.ar_addr  = rand_addr();
                    bus.ar_valid = 1'b1;
                    rand_left--;
                end
            end
            #1;
            if (bus.ar_valid && bus.ar_ready && !rst) begin
                m = model_decode(bus.ar_addr);
                e.hit      = (m >= 0);
                e.slv      = (m >= 0) ? m : 0;
                e.off      = bus.ar_addr[OW-1:0];
                e.word     = (m >= 0) ? slave_word(m, e.off)
                                      : {32'd0, IC_RESP_DECERR};
                e.acc      = cyc;
                e.req_done = 1'b0;
                sb.push_back(e);
                n_acc++;
                acc_last = 1'b1;
            end
        end
    end

    // Slave node models plus response noise on the other columns.
    initial begin : slave_model
        bit            pend;
        int            ps, dly, wcnt;
        logic [OW-1:0] poff;
        pend = 1'b0; ps = 0; dly = 0; wcnt = 0; poff = '0;
        reqst_rdy = '0; resp_val = '0; resp_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0; wcnt = 0;
                reqst_rdy = '0; resp_val = '0;
                continue;
            end
            for (int i = 0; i < NS; i++) begin
                reqst_rdy[i] = ($urandom_range(0, 99) < rdy_pct)
                               && (wcnt >= req_stall);
                if (pend && i == ps) begin
                    if (dly > 0) resp_val[i] = 1'b0;
                    else begin
                        resp_val[i]  = 1'b1;
                        resp_data[i] = slave_word(i, poff);
                    end
                end else if (noise) begin
                    resp_val[i]  = 1'($urandom_range(0, 1));
                    resp_data[i] = {$urandom, 2'($urandom)};
                end else begin
                    resp_val[i] = 1'b0;
                end
            end
            if (pend && dly > 0) dly--;
            #1;
            if (rst) continue;
            if (pend && resp_val[ps] && resp_rdy[ps]) pend = 1'b0;
            else if (reqst_val != '0) begin
                wcnt++;
                for (int i = 0; i < NS; i++) begin
                    if (reqst_val[i] && reqst_rdy[i]) begin
                        pend = 1'b1;
                        ps   = i;
                        poff = reqst_data;
                        dly  = $urandom_range(0, resp_dly_max);
                        wcnt = 0;
                    end
                end
            end
        end
    end

    // R ready driver with optional initial backpressure.
    initial begin : r_driver
        int rc;
        rc = 0;
        bus.r_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.r_ready = 1'b0;
                rc = 0;
                continue;
            end
            bus.r_ready = (rc >= rr_stall) && ($urandom_range(0, 99) < rr_pct);
            #1;
            if (bus.r_valid && bus.r_ready) rc = 0;
            else if (bus.r_valid) rc++;
        end
    end

    // Monitor: per-cycle control expectations and R beat scoreboard.
    initial begin : monitor
        bit            act, hit, done;
        int            s;
        logic          e_rv;
        logic [NS-1:0] e_rq, e_rr;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                sb.delete();
                continue;
            end
            act  = (sb.size() > 0) && (sb[0].acc < cyc);
            hit  = act && sb[0].hit;
            s    = act ? sb[0].slv : 0;
            done = act && sb[0].req_done;
            e_rq = (hit && !done) ? oh(s) : '0;
            e_rv = act && (!hit || (done && resp_val[s]));
            e_rr = (hit && done && bus.r_ready) ? oh(s) : '0;
            check("ctl", {bus.ar_ready, bus.r_valid, reqst_val, resp_rdy},
                  {!act, e_rv, e_rq, e_rr});
            if (!act || (hit && !done))
                check("r_zero", {bus.r_data, bus.r_resp}, '0);
            if (hit && !done)
                check("rq_data", reqst_data, sb[0].off);
            if (e_rv && bus.r_ready) begin
                check("r_beat", {bus.r_data, bus.r_resp}, sb[0].word);
                void'(sb.pop_front());
                n_done++;
            end else if (hit && !done && reqst_rdy[s]) begin
                sb[0].req_done = 1'b1;
            end
        end
    end

    initial begin : main
        int n, base_acc, base_done;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset_vals");
        @(negedge clk);
        #3 rst = 1'b0;

        ar_q.push_back({IC_SLV_BASE[2], 20'h00001});
        wait_drain("hit_fast", 50);

        req_stall = 5;
        ar_q.push_back({IC_SLV_BASE[1], 20'h5A5A4});
        wait_drain("req_stall", 50);
        req_stall = 0;

        ar_q.push_back({12'hABC, 20'h12345});
        ar_q.push_back({IC_SLV_BASE[3], 20'h00040});
        wait_drain("decerr", 50);

        rr_stall = 4;
        noise = 1'b1;
        ar_q.push_back({IC_SLV_BASE[0], 20'hC0DE8});
        ar_q.push_back({IC_SLV_BASE[2], 20'h0F00C});
        wait_drain("backpressure", 80);

        rr_stall = 50;
        ar_q.push_back({IC_SLV_BASE[2], 20'h0BEEF});
        n = 0;
        while (!(sb.size() > 0 && sb[0].req_done && bus.r_valid) && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("reach_resp", 128'(n < 50), 128'(1));
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        rr_stall = 0;
        ar_q.push_back({IC_SLV_BASE[0], 20'h00770});
        wait_drain("after_rst", 50);

        rdy_pct = 60; resp_dly_max = 3; rr_pct = 60; noise = 1'b1;
        base_acc  = n_acc;
        base_done = n_done;
        rand_left = 1000;
        wait_drain("random", 40000);
        check("rand_acc", 128'(n_acc - base_acc), 128'(1000));
        check("rand_done", 128'(n_done - base_done), 128'(1000));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
